// File: rtl/frame_position_sampler_if.sv
// frame_position_sampler_if: frame trigger, position input and pixel
// coordinate outputs of the frame position sampler.
interface frame_position_sampler_if #(
  parameter int SPRITES    = 1,
  parameter int WIDTH      = 32,
  parameter int DIMENSIONS = 2
);
  logic frame_start;
  logic loc_valid;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] locations;
  logic [SPRITES-1:0][10:0] sprite_row;
  logic [SPRITES-1:0][11:0] sprite_col;
  logic busy;
  logic [15:0] frame_count;
  logic missed;

  modport master (
    output frame_start, loc_valid, locations,
    input  sprite_row, sprite_col, busy, frame_count, missed
  );

  modport slave (
    input  frame_start, loc_valid, locations,
    output sprite_row, sprite_col, busy, frame_count, missed
  );
endinterface

// File: rtl/frame_position_sampler.sv
// frame_position_sampler: snapshots 16.16 body positions at vblank and commits
// pixel coordinates atomically. Define SAMPLER_CLAMP_EN to saturate results.
module frame_position_sampler #(
  parameter int SPRITES    = 1,
  parameter int WIDTH      = 32,
  parameter int DIMENSIONS = 2
) (
  input logic clk,
  input logic rst,
  frame_position_sampler_if.slave bus
);
  localparam int IXW = (SPRITES > 1) ? $clog2(SPRITES) : 1;
  localparam logic [IXW-1:0] LAST = IXW'(SPRITES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CONV, COMMIT} state_t;

  state_t state;
  logic [IXW-1:0] idx;
  logic busy;
  logic missed;
  logic [15:0] frame_count;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] shadow;
  logic [SPRITES-1:0][10:0] stage_row;
  logic [SPRITES-1:0][11:0] stage_col;
  logic [SPRITES-1:0][10:0] rows;
  logic [SPRITES-1:0][11:0] cols;

  function automatic logic [11:0] to_col(input logic [WIDTH-1:0] x);
    logic signed [17:0] s;
    s = 18'sd800 + 18'(signed'(x) >>> 16);
`ifdef SAMPLER_CLAMP_EN
    if (s < 18'sd0) return 12'd0;
    if (s > 18'sd1599) return 12'd1599;
`endif
    return s[11:0];
  endfunction

  // y points up on screen, rows count down
  function automatic logic [10:0] to_row(input logic [WIDTH-1:0] y);
    logic signed [17:0] s;
    s = 18'sd600 - 18'(signed'(y) >>> 16);
`ifdef SAMPLER_CLAMP_EN
    if (s < 18'sd0) return 11'd0;
    if (s > 18'sd1199) return 11'd1199;
`endif
    return s[10:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      missed      <= 1'b0;
      frame_count <= 16'd0;
      shadow      <= '0;
      stage_row   <= '0;
      stage_col   <= '0;
      rows        <= {SPRITES{11'd600}};
      cols        <= {SPRITES{12'd800}};
    end else begin
      if (bus.frame_start && state != IDLE)
        missed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.loc_valid) begin
            shadow <= bus.locations;
            idx    <= '0;
            state  <= CONV;
          end
        end
        CONV: begin
          stage_row[idx] <= to_row(shadow[idx][1]);
          stage_col[idx] <= to_col(shadow[idx][0]);
          if (idx == LAST)
            state <= COMMIT;
          else
            idx <= idx + 1'b1;
        end
        COMMIT: begin
          rows        <= stage_row;
          cols        <= stage_col;
          frame_count <= frame_count + 16'd1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sprite_row  = rows;
  assign bus.sprite_col  = cols;
  assign bus.busy        = busy;
  assign bus.frame_count = frame_count;
  assign bus.missed      = missed;
endmodule

// File: tb/tb_frame_position_sampler.sv
// tb_frame_position_sampler: random frames against a scoreboard of
// expected commits; a monitor checks every frame_count change.
module tb_frame_position_sampler;
  localparam int S = 4;
  localparam int W = 32;

  typedef logic [S-1:0][1:0][W-1:0] loc_t;
  typedef struct {
    logic [S-1:0][10:0] row;
    logic [S-1:0][11:0] col;
    logic [15:0] fc;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int model_fc = 0;
  bit missed_m = 1'b0;
  exp_t sb[$];

  frame_position_sampler_if #(.SPRITES(S), .WIDTH(W), .DIMENSIONS(2)) bus ();

  frame_position_sampler #(.SPRITES(S), .WIDTH(W), .DIMENSIONS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic logic [11:0] m_col(input logic [31:0] x);
    int xi;
    int c;
    xi = $signed(x) >>> 16;
    c = 800 + xi;
`ifdef SAMPLER_CLAMP_EN
    if (c < 0) c = 0;
    if (c > 1599) c = 1599;
`else
    c = c & 4095;
`endif
    return c[11:0];
  endfunction

  function automatic logic [10:0] m_row(input logic [31:0] y);
    int yi;
    int r;
    yi = $signed(y) >>> 16;
    r = 600 - yi;
`ifdef SAMPLER_CLAMP_EN
    if (r < 0) r = 0;
    if (r > 1199) r = 1199;
`else
    r = r & 2047;
`endif
    return r[10:0];
  endfunction

  // monitor: a frame_count change is a commit; otherwise outputs must hold
  logic [S-1:0][10:0] last_row;
  logic [S-1:0][11:0] last_col;
  logic [15:0] last_fc;
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      last_row = bus.sprite_row;
      last_col = bus.sprite_col;
      last_fc  = bus.frame_count;
    end else if (bus.frame_count !== last_fc) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_commit fc=%0d cyc=%0d", bus.frame_count, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.sprite_row !== e.row || bus.sprite_col !== e.col ||
            bus.frame_count !== e.fc || cyc != e.cyc) begin
          bad++;
          $display("FAIL commit got row=%h col=%h fc=%0d cyc=%0d want row=%h col=%h fc=%0d cyc=%0d",
                   bus.sprite_row, bus.sprite_col, bus.frame_count, cyc,
                   e.row, e.col, e.fc, e.cyc);
        end
      end
      last_row = bus.sprite_row;
      last_col = bus.sprite_col;
      last_fc  = bus.frame_count;
    end else begin
      total++;
      if (bus.sprite_row !== last_row || bus.sprite_col !== last_col) begin
        bad++;
        $display("FAIL output_hold got row=%h col=%h want row=%h col=%h cyc=%0d",
                 bus.sprite_row, bus.sprite_col, last_row, last_col, cyc);
        last_row = bus.sprite_row;
        last_col = bus.sprite_col;
      end
    end
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, want, cyc);
    end
  endtask

  task automatic push_exp(input loc_t l, input int c);
    exp_t e;
    for (int i = 0; i < S; i++) begin
      e.row[i] = m_row(l[i][1]);
      e.col[i] = m_col(l[i][0]);
    end
    model_fc = (model_fc + 1) % 65536;
    e.fc  = 16'(model_fc);
    e.cyc = c;
    sb.push_back(e);
  endtask

  function automatic loc_t rand_locs();
    loc_t l;
    int ip;
    for (int i = 0; i < S; i++)
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 7) == 0) begin
          l[i][d] = $urandom;
        end else begin
          ip = int'($urandom_range(0, 2400)) - 1200;
          l[i][d] = {ip[15:0], 16'($urandom)};
        end
      end
    return l;
  endfunction

  // rst sampled on the next edge; outputs checked right after it
  task automatic do_reset();
    logic [S-1:0][10:0] r0;
    logic [S-1:0][11:0] c0;
    for (int i = 0; i < S; i++) begin
      r0[i] = 11'd600;
      c0[i] = 12'd800;
    end
    bus.frame_start = 1'b0;
    rst = 1'b1;
    tick(1);
    chk("rst_row", 64'(bus.sprite_row), 64'(r0));
    chk("rst_col", 64'(bus.sprite_col), 64'(c0));
    chk("rst_fc", 64'(bus.frame_count), 64'd0);
    chk("rst_missed", 64'(bus.missed), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    sb.delete();
    model_fc = 0;
    missed_m = 1'b0;
    rst = 1'b0;
  endtask

  // extra: 0 none, 1 frame_start in first CONV cycle, 2 in COMMIT, 3 during WAIT
  task automatic frame(input loc_t l, input int delay, input bit scramble, input int extra);
    int fs;
    int lv;
    fs = cyc;
    bus.locations   = l;
    bus.frame_start = 1'b1;
    bus.loc_valid   = (delay == 0);
    tick(1);
    bus.frame_start = 1'b0;
    chk("busy_wait", 64'(bus.busy), 64'd1);
    if (delay > 0) begin
      if (extra == 3) begin
        bus.frame_start = 1'b1;
        missed_m = 1'b1;
      end
      tick(1);
      bus.frame_start = 1'b0;
      tick(delay - 1);
      bus.loc_valid = 1'b1;
    end
    lv = fs + 1 + delay;
    push_exp(l, lv + S + 2);
    for (int k = 1; k <= S + 1; k++) begin
      tick(1);
      bus.frame_start = (extra == 1 && k == 1) || (extra == 2 && k == S + 1);
      if (bus.frame_start) missed_m = 1'b1;
      if (scramble && k == 1) bus.locations = rand_locs();
    end
    tick(1);
    bus.frame_start = 1'b0;
    chk("busy_idle", 64'(bus.busy), 64'd0);
    chk("missed", 64'(bus.missed), 64'(missed_m));
    chk("frame_count", 64'(bus.frame_count), 64'(model_fc));
  endtask

  initial begin
    loc_t l;
    int fs;
    bus.frame_start = 1'b0;
    bus.loc_valid   = 1'b0;
    bus.locations   = '0;
    tick(3);
    do_reset();
    tick(5);

    l = '0;
    frame(l, 0, 1'b0, 0);

    l = '0;
    l[0][0] = 32'h0001_8000; l[0][1] = 32'h0002_0000;
    l[1][0] = 32'hFFFF_0000; l[1][1] = 32'hFFFE_8000;
    l[2][0] = 32'h0064_0000; l[2][1] = 32'h0000_0000;
    frame(l, 0, 1'b0, 0);

    l = '0;
    l[0][0] = 32'h0400_0000; l[0][1] = 32'hFC00_0000;
    l[3][0] = 32'hFC00_0000; l[3][1] = 32'h0400_0000;
    frame(l, 0, 1'b0, 0);

    frame(rand_locs(), 0, 1'b1, 0);
    frame(rand_locs(), 2, 1'b0, 2);

    do_reset();
    tick(2);
    frame(rand_locs(), 50, 1'b0, 3);
    chk("fc_after_wait", 64'(bus.frame_count), 64'd1);

    // reset lands in the second conversion cycle
    tick(2);
    fs = cyc;
    bus.locations   = rand_locs();
    bus.loc_valid   = 1'b1;
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
    tick(1);
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
    chk("missed_pre_rst", 64'(bus.missed), 64'd1);
    chk("conv_cycle", 64'(cyc - fs), 64'd3);
    do_reset();
    frame(rand_locs(), 0, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      int d;
      int x;
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      x = int'($urandom_range(0, 3));
      if (x == 3 && d == 0) x = 0;
      if ($urandom_range(0, 4) == 0) x = 0;
      frame(rand_locs(), d, 1'($urandom_range(0, 1)), x);
      bus.loc_valid = 1'($urandom_range(0, 1));
      tick(int'($urandom_range(0, 3)));
    end

    tick(S + 6);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
